// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, write-back source
// identifiers and the result bundle carried from execute to write-back.
package cpu_pkg;

    localparam int XLEN       = 32;
    localparam int NREGS      = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_MEM = 1'b1
    } wb_src_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register,
// set on issue, cleared on write-back, with combinational busy lookups.
module reg_scoreboard
    import cpu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en_i,
    input  logic [REG_ADDR_W-1:0] set_addr_i,
    input  logic                  clr_en_i,
    input  logic [REG_ADDR_W-1:0] clr_addr_i,
    input  logic [REG_ADDR_W-1:0] rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] rs2_addr_i,
    input  logic [REG_ADDR_W-1:0] chk_addr_i,
    output logic                  rs1_busy_o,
    output logic                  rs2_busy_o,
    output logic                  chk_busy_o
);

    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;

    always_comb begin
        pending_d = pending_q;
        if (clr_en_i) begin
            pending_d[clr_addr_i] = 1'b0;
        end
        if (set_en_i && set_addr_i != '0) begin
            pending_d[set_addr_i] = 1'b1;
        end
        // x0 is never a real destination
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign rs1_busy_o = pending_q[rs1_addr_i];
    assign rs2_busy_o = pending_q[rs2_addr_i];
    assign chk_busy_o = pending_q[chk_addr_i];

endmodule

// File: rtl/wb_scoreboard_arbiter.sv
// Write-back controller: round-robin ALU/load arbitration onto the single
// register-file write port, registered output stage, hazard scoreboard.
module wb_scoreboard_arbiter
    import cpu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    output logic                  issue_ready,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    output logic                  alu_ready,
    input  logic                  mem_valid,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]       mem_data,
    output logic                  mem_ready,
    output logic                  rf_write_enable,
    output logic [REG_ADDR_W-1:0] rf_write_reg,
    output logic [XLEN-1:0]       rf_write_data
);

    wb_src_e               prio_q, prio_d;
    logic                  we_q, we_d;
    logic [REG_ADDR_W-1:0] wreg_q, wreg_d;
    logic [XLEN-1:0]       wdata_q, wdata_d;

    wb_req_t alu_req, mem_req, sel_req;
    logic    gnt_alu, gnt_mem;
    logic    rd_busy, set_en;

    assign alu_req = '{rd: alu_rd, data: alu_data};
    assign mem_req = '{rd: mem_rd, data: mem_data};

    // mem wins a tie only when it holds priority
    assign gnt_mem = mem_valid && (!alu_valid || prio_q == WB_MEM);
    assign gnt_alu = alu_valid && !gnt_mem;

    assign alu_ready = gnt_alu;
    assign mem_ready = gnt_mem;

    always_comb begin
        prio_d  = prio_q;
        sel_req = alu_req;
        we_d    = 1'b0;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        if (gnt_mem) begin
            prio_d  = WB_ALU;
            sel_req = mem_req;
        end else if (gnt_alu) begin
            prio_d  = WB_MEM;
        end
        if (gnt_mem || gnt_alu) begin
            we_d    = sel_req.rd != '0;
            wreg_d  = sel_req.rd;
            wdata_d = sel_req.data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q  <= WB_MEM;
            we_q    <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
        end else begin
            prio_q  <= prio_d;
            we_q    <= we_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
        end
    end

    assign rf_write_enable = we_q;
    assign rf_write_reg    = wreg_q;
    assign rf_write_data   = wdata_q;

    // A pending destination blocks issue (WAW); x0 never does
    assign issue_ready = !rd_busy || issue_rd == '0;
    assign set_en      = issue_valid && issue_ready;

    reg_scoreboard u_sb (
        .clk        (clk),
        .rst        (rst),
        .set_en_i   (set_en),
        .set_addr_i (issue_rd),
        .clr_en_i   (we_q),
        .clr_addr_i (wreg_q),
        .rs1_addr_i (rs1_addr),
        .rs2_addr_i (rs2_addr),
        .chk_addr_i (issue_rd),
        .rs1_busy_o (rs1_busy),
        .rs2_busy_o (rs2_busy),
        .chk_busy_o (rd_busy)
    );

endmodule

// File: tb/tb_wb_scoreboard_arbiter.sv
// Self-checking bench for wb_scoreboard_arbiter: directed scenarios plus
// randomized traffic against a behavioural reference model.
module tb_wb_scoreboard_arbiter;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        rs1_busy, rs2_busy;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        rf_write_enable;
    logic [4:0]  rf_write_reg;
    logic [31:0] rf_write_data;

    int vecs;
    int errs;

    // reference model state
    bit [31:0] mpend;
    bit        mprio;
    bit        mwe;
    bit [4:0]  mreg;
    bit [31:0] mdata;

    wb_scoreboard_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .issue_valid     (issue_valid),
        .issue_rd        (issue_rd),
        .issue_ready     (issue_ready),
        .rs1_addr        (rs1_addr),
        .rs2_addr        (rs2_addr),
        .rs1_busy        (rs1_busy),
        .rs2_busy        (rs2_busy),
        .alu_valid       (alu_valid),
        .alu_rd          (alu_rd),
        .alu_data        (alu_data),
        .alu_ready       (alu_ready),
        .mem_valid       (mem_valid),
        .mem_rd          (mem_rd),
        .mem_data        (mem_data),
        .mem_ready       (mem_ready),
        .rf_write_enable (rf_write_enable),
        .rf_write_reg    (rf_write_reg),
        .rf_write_data   (rf_write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit m_gnt_mem();
        if (!mem_valid) return 1'b0;
        if (!alu_valid) return 1'b1;
        return mprio;
    endfunction

    function automatic bit m_gnt_alu();
        return alu_valid && !m_gnt_mem();
    endfunction

    function automatic bit m_issue_ok();
        return issue_rd == 5'd0 || !mpend[issue_rd];
    endfunction

    task automatic model_reset();
        mpend = '0;
        mprio = 1'b1;
        mwe   = 1'b0;
        mreg  = '0;
        mdata = '0;
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0;
        issue_rd    = '0;
        rs1_addr    = '0;
        rs2_addr    = '0;
        alu_valid   = 1'b0;
        alu_rd      = '0;
        alu_data    = '0;
        mem_valid   = 1'b0;
        mem_rd      = '0;
        mem_data    = '0;
    endtask

    // Advance one clock and the model alongside it; returns at posedge+1.
    task automatic tick();
        bit [31:0] np;
        bit        gm, ga, nwe, nprio;
        bit [4:0]  nreg;
        bit [31:0] ndata;
        gm    = m_gnt_mem();
        ga    = m_gnt_alu();
        np    = mpend;
        nwe   = 1'b0;
        nreg  = mreg;
        ndata = mdata;
        nprio = mprio;
        if (mwe) np[mreg] = 1'b0;
        if (issue_valid && issue_rd != 0 && !mpend[issue_rd]) np[issue_rd] = 1'b1;
        if (gm) begin
            nwe = mem_rd != 0; nreg = mem_rd; ndata = mem_data; nprio = 1'b0;
        end else if (ga) begin
            nwe = alu_rd != 0; nreg = alu_rd; ndata = alu_data; nprio = 1'b1;
        end
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            mpend = np; mwe = nwe; mreg = nreg; mdata = ndata; mprio = nprio;
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        issue_rd = 5'd17;
        rs1_addr = 5'd17;
        rs2_addr = 5'd31;
        #1;
        vecs++;
        if (rf_write_enable !== 1'b0) begin
            errs++; $display("FAIL reset_we: got %0b want 0", rf_write_enable);
        end
        vecs++;
        if (rf_write_reg !== 5'd0 || rf_write_data !== 32'd0) begin
            errs++; $display("FAIL reset_regdata: got %0d/%h want 0/0", rf_write_reg, rf_write_data);
        end
        vecs++;
        if (issue_ready !== 1'b1) begin
            errs++; $display("FAIL reset_issue_ready: got %0b want 1", issue_ready);
        end
        vecs++;
        if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
            errs++; $display("FAIL reset_busy: got %0b%0b want 00", rs1_busy, rs2_busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_alu();
        do_reset();
        issue_valid = 1'b1; issue_rd = 5'd5; rs1_addr = 5'd5;
        #1;
        vecs++;
        if (issue_ready !== 1'b1) begin
            errs++; $display("FAIL single_issue_ready: got %0b want 1", issue_ready);
        end
        tick();
        issue_valid = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            #1;
            vecs++;
            if (rs1_busy !== 1'b1) begin
                errs++; $display("FAIL single_busy_c%0d: got %0b want 1", c, rs1_busy);
            end
            tick();
        end
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        vecs++;
        if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
            errs++; $display("FAIL single_grant: got alu=%0b mem=%0b want 1/0", alu_ready, mem_ready);
        end
        tick();
        alu_valid = 1'b0;
        #1;
        vecs++;
        if (rf_write_enable !== 1'b1 || rf_write_reg !== 5'd5 || rf_write_data !== 32'hDEADBEEF) begin
            errs++;
            $display("FAIL single_write: got %0b/%0d/%h want 1/5/deadbeef",
                     rf_write_enable, rf_write_reg, rf_write_data);
        end
        vecs++;
        if (rs1_busy !== 1'b1) begin
            errs++; $display("FAIL single_busy_c4: got %0b want 1", rs1_busy);
        end
        tick();
        #1;
        vecs++;
        if (rs1_busy !== 1'b0) begin
            errs++; $display("FAIL single_busy_c5: got %0b want 0", rs1_busy);
        end
        vecs++;
        if (rf_write_enable !== 1'b0 || rf_write_data !== 32'hDEADBEEF) begin
            errs++; $display("FAIL single_hold: got %0b/%h want 0/deadbeef", rf_write_enable, rf_write_data);
        end
    endtask

    task automatic test_contention();
        bit [4:0] aq [2];
        bit [4:0] mq [3];
        bit [4:0] order [4];
        int ai, mi;
        aq = '{5'd1, 5'd4};
        mq = '{5'd2, 5'd3, 5'd5};
        order = '{5'd2, 5'd1, 5'd3, 5'd4};
        ai = 0; mi = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1'b1; alu_rd = aq[ai]; alu_data = 32'hA000 + 32'(aq[ai]);
            mem_valid = 1'b1; mem_rd = mq[mi]; mem_data = 32'hB000 + 32'(mq[mi]);
            #1;
            vecs++;
            if (mem_ready !== ((i % 2) == 0) || alu_ready !== ((i % 2) == 1)) begin
                errs++;
                $display("FAIL contention_grant_%0d: got mem=%0b alu=%0b want mem=%0b",
                         i, mem_ready, alu_ready, (i % 2) == 0);
            end
            if (i > 0) begin
                vecs++;
                if (rf_write_enable !== 1'b1 || rf_write_reg !== order[i-1]) begin
                    errs++;
                    $display("FAIL contention_write_%0d: got %0b/%0d want 1/%0d",
                             i, rf_write_enable, rf_write_reg, order[i-1]);
                end
            end
            if ((i % 2) == 0) mi++; else ai++;
            tick();
        end
        alu_valid = 1'b0;
        #1;
        vecs++;
        if (rf_write_reg !== 5'd4 || rf_write_data !== 32'hA004) begin
            errs++; $display("FAIL contention_last: got %0d/%h want 4/a004", rf_write_reg, rf_write_data);
        end
        vecs++;
        if (mem_ready !== 1'b1) begin
            errs++; $display("FAIL contention_held_mem: got %0b want 1", mem_ready);
        end
        tick();
        mem_valid = 1'b0;
        #1;
        vecs++;
        if (rf_write_reg !== 5'd5 || rf_write_data !== 32'hB005) begin
            errs++; $display("FAIL contention_mem5: got %0d/%h want 5/b005", rf_write_reg, rf_write_data);
        end
    endtask

    task automatic test_waw();
        bit exp_rdy [4];
        exp_rdy = '{1'b1, 1'b0, 1'b0, 1'b1};
        do_reset();
        issue_valid = 1'b1; issue_rd = 5'd7; rs1_addr = 5'd7;
        for (int c = 0; c < 4; c++) begin
            alu_valid = (c == 1); alu_rd = 5'd7; alu_data = 32'h77;
            #1;
            vecs++;
            if (issue_ready !== exp_rdy[c]) begin
                errs++; $display("FAIL waw_ready_c%0d: got %0b want %0b", c, issue_ready, exp_rdy[c]);
            end
            tick();
        end
        issue_valid = 1'b0;
        #1;
        vecs++;
        if (rs1_busy !== 1'b1) begin
            errs++; $display("FAIL waw_rebusy: got %0b want 1", rs1_busy);
        end
    endtask

    task automatic test_x0();
        do_reset();
        issue_valid = 1'b1; issue_rd = 5'd0; rs1_addr = 5'd0; rs2_addr = 5'd0;
        #1;
        vecs++;
        if (issue_ready !== 1'b1) begin
            errs++; $display("FAIL x0_issue_ready: got %0b want 1", issue_ready);
        end
        tick();
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234_5678;
        #1;
        vecs++;
        if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
            errs++; $display("FAIL x0_busy: got %0b%0b want 00", rs1_busy, rs2_busy);
        end
        vecs++;
        if (alu_ready !== 1'b1) begin
            errs++; $display("FAIL x0_alu_ready: got %0b want 1", alu_ready);
        end
        tick();
        alu_valid = 1'b0;
        #1;
        vecs++;
        if (rf_write_enable !== 1'b0) begin
            errs++; $display("FAIL x0_no_write: got %0b want 0", rf_write_enable);
        end
    endtask

    task automatic test_independent();
        do_reset();
        issue_valid = 1'b1; issue_rd = 5'd3;
        tick();
        issue_rd = 5'd9;
        tick();
        issue_valid = 1'b0;
        mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h9999;
        tick();
        mem_valid = 1'b0;
        tick();
        rs1_addr = 5'd9; rs2_addr = 5'd3;
        #1;
        vecs++;
        if (rs1_busy !== 1'b0) begin
            errs++; $display("FAIL indep_busy9: got %0b want 0", rs1_busy);
        end
        vecs++;
        if (rs2_busy !== 1'b1) begin
            errs++; $display("FAIL indep_busy3: got %0b want 1", rs2_busy);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        issue_valid = 1'b1; issue_rd = 5'd12;
        tick();
        issue_rd = 5'd20;
        alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hC0C0;
        tick();
        idle_inputs();
        #1;
        vecs++;
        if (rf_write_enable !== 1'b1) begin
            errs++; $display("FAIL midrst_pre_we: got %0b want 1", rf_write_enable);
        end
        rst = 1'b1;
        issue_rd = 5'd20;
        #1;
        vecs++;
        if (rf_write_enable !== 1'b0) begin
            errs++; $display("FAIL midrst_we: got %0b want 0", rf_write_enable);
        end
        vecs++;
        if (issue_ready !== 1'b1) begin
            errs++; $display("FAIL midrst_issue_ready: got %0b want 1", issue_ready);
        end
        for (int a = 0; a < 32; a++) begin
            rs1_addr = 5'(a);
            #1;
            vecs++;
            if (rs1_busy !== 1'b0) begin
                errs++; $display("FAIL midrst_busy_%0d: got %0b want 0", a, rs1_busy);
            end
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_random();
        bit ag, mg;
        ag = 1'b0; mg = 1'b0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (!alu_valid || ag) begin
                alu_valid = 1'($urandom_range(0, 1));
                alu_rd    = 5'($urandom_range(0, 7));
                alu_data  = $urandom;
            end
            if (!mem_valid || mg) begin
                mem_valid = 1'($urandom_range(0, 1));
                mem_rd    = 5'($urandom_range(0, 7));
                mem_data  = $urandom;
            end
            issue_valid = 1'($urandom_range(0, 1));
            issue_rd    = 5'($urandom_range(0, 7));
            rs1_addr    = 5'($urandom_range(0, 7));
            rs2_addr    = 5'($urandom_range(0, 31));
            #1;
            vecs++;
            if (issue_ready !== m_issue_ok()) begin
                errs++; $display("FAIL rnd_issue_ready c%0d: got %0b want %0b", c, issue_ready, m_issue_ok());
            end
            vecs++;
            if (rs1_busy !== mpend[rs1_addr] || rs2_busy !== mpend[rs2_addr]) begin
                errs++;
                $display("FAIL rnd_busy c%0d: got %0b%0b want %0b%0b",
                         c, rs1_busy, rs2_busy, mpend[rs1_addr], mpend[rs2_addr]);
            end
            vecs++;
            if (alu_ready !== m_gnt_alu() || mem_ready !== m_gnt_mem()) begin
                errs++;
                $display("FAIL rnd_grant c%0d: got alu=%0b mem=%0b want alu=%0b mem=%0b",
                         c, alu_ready, mem_ready, m_gnt_alu(), m_gnt_mem());
            end
            vecs++;
            if (rf_write_enable !== mwe || rf_write_reg !== mreg || rf_write_data !== mdata) begin
                errs++;
                $display("FAIL rnd_wb c%0d: got %0b/%0d/%h want %0b/%0d/%h",
                         c, rf_write_enable, rf_write_reg, rf_write_data, mwe, mreg, mdata);
            end
            ag = m_gnt_alu();
            mg = m_gnt_mem();
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        test_reset();
        test_single_alu();
        test_contention();
        test_waw();
        test_x0();
        test_independent();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/wb_scoreboard_arbiter.md
# wb_scoreboard_arbiter

Write-back controller for the 32x32 register file. Shares the register file's single write port between the ALU and load-unit result sources with round-robin arbitration. Drives the write port from a registered stage, and keeps a pending-write scoreboard so decode can stall on RAW and WAW hazards. Sits between the execute/memory units and the register file; decode queries it every cycle.

## Interface
- XLEN, 32, data width.
- NREGS, 32, architectural registers; register index width is log2(NREGS) = 5.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- issue_valid  in  1  decode issues an instruction that will write issue_rd.
- issue_rd  in  5  destination register of the issuing instruction.
- issue_ready  out  1  issue is accepted this cycle.
- rs1_addr, rs2_addr  in  5 each  source registers queried by decode.
- rs1_busy, rs2_busy  out  1 each  the queried register has a pending write.
- alu_valid  in  1  ALU result available.
- alu_rd  in  5  ALU destination register.
- alu_data  in  XLEN  ALU result.
- alu_ready  out  1  ALU result accepted this cycle.
- mem_valid, mem_rd, mem_data, mem_ready  same as the alu_* ports, for load results.
- rf_write_enable  out  1  register-file write enable.
- rf_write_reg  out  5  register-file write address.
- rf_write_data  out  XLEN  register-file write data.

## Operation
- **Scoreboard:** pending[31:0], one bit per register; pending[0] is hard 0.
- **rs busy outputs:** rsN_busy = pending[rsN_addr]; combinational; always 0 for x0.
- **issue_ready:** issue_ready = !pending[issue_rd] || issue_rd == 0. This is the WAW stall.
- **Issue handshake:** issue_valid && issue_ready sets pending[issue_rd] at the clock edge. x0 is never set.
- **Arbiter state:** 1-bit prio_mem; reset value 1.
- **Grant rules:**
  - Only one of alu_valid/mem_valid is high: that source is granted.
  - Both are high: mem is granted if prio_mem, else alu.
  - After any grant, prio_mem points to the non-granted source: it becomes 0 after a mem grant and 1 after an alu grant.
  - prio_mem is unchanged when nothing is granted.
- **Ready outputs:** alu_ready/mem_ready equal their grant and are combinational from the valid inputs and prio_mem. At most one grant per cycle.
- **Output stage:** the granted rd/data are registered into rf_write_reg/rf_write_data. rf_write_enable is registered as (grant && rd != 0). With no grant, rf_write_enable goes 0 and reg/data hold their previous values.
- **Scoreboard clear:** the cycle rf_write_enable is 1, pending[rf_write_reg] clears at the end of that cycle.
- **Simultaneous set and clear on one register:** not reachable, because issue_ready is low while the register is pending.
- **Write to x0 from a requester:** accepted (ready=1); no write is performed and no scoreboard change occurs.
- **Write to a non-pending register:** written normally; the clear is a no-op.

## Timing
- **Reset values:** pending all 0, prio_mem 1, rf_write_enable 0, rf_write_reg 0, rf_write_data 0. Combinationally: issue_ready 1 and both rs busy outputs 0 after reset.
- **Reset mid-operation:** asynchronous; in-flight writes in the output stage are discarded and all pending bits clear.
- **Write latency:** a result granted in cycle N gives rf_write_enable=1 in cycle N+1, and the register file stores it at the end of N+1.
- **Busy window:** pending clears at the end of N+1, so rs busy drops in N+2. In N+2, the register file's combinational read returns the new value; there is no bypass.
- **Issue latency:** an issue accepted in cycle M makes rs busy read 1 from cycle M+1.
- **Throughput:** one write per cycle. With both sources continuously valid, grants alternate mem, alu, mem, ...
- **Held requests:** a non-granted source must hold valid/rd/data stable until ready.

## Structure
- **Shared package cpu_pkg:**
  - XLEN and REG_ADDR_W (=5) constants.
  - wb_src_e enum {WB_ALU, WB_MEM}, used for the last-grant/priority state.
  - A wb_req_t struct {rd, data}.
- **Sub-module reg_scoreboard:** the pending vector, set/clear logic and the two busy read ports. The arbiter and output register stay in the top module.

## Test plan
- **Reset:** assert rst mid-traffic -> rf_write_enable=0 immediately, rs1_busy=0 for every address, issue_ready=1.
- **Single ALU write:** issue rd=5 in cycle 0 -> rs1_busy(5)=1 from cycle 1. alu_valid, rd=5, data=0xDEADBEEF in cycle 3 -> rf_write_enable=1, reg=5, data=0xDEADBEEF in cycle 4; rs1_busy(5)=0 in cycle 5.
- **Contention:** alu and mem both valid for 4 cycles after reset (rd=1..4) -> grant order mem, alu, mem, alu; each non-granted source is held and written on its next grant.
- **WAW stall:** issue rd=7 twice back-to-back -> second issue_ready=0 until the cycle after the rd=7 write-back retires.
- **x0:** issue rd=0 -> issue_ready=1 and pending unchanged. alu_valid with rd=0 -> alu_ready=1 and rf_write_enable stays 0.
- **Independent registers:** pending on rd=3 and rd=9; write-back of rd=9 only -> rs busy for 9 drops and for 3 stays 1.
